// File: rtl/inst_fetch_unit_if.sv
// Purpose : DDR read channel between the instruction fetch unit (master) and
//           the memory controller (slave): burst request handshake plus the
//           un-throttled read data return.
// Signals : rd_req_valid/rd_req_ready  request handshake
//           rd_req_addr                burst start byte address
//           rd_req_len                 beats in burst (1..MAX_BURST)
//           rd_data_valid/rd_data      one returned beat, no back-pressure
interface inst_fetch_unit_if #(
    parameter int unsigned DDR_ADDR_LEN = 32,
    parameter int unsigned DDR_DATA_W   = 256
) ();
    logic                    rd_req_valid;
    logic                    rd_req_ready;
    logic [DDR_ADDR_LEN-1:0] rd_req_addr;
    logic [7:0]              rd_req_len;
    logic                    rd_data_valid;
    logic [DDR_DATA_W-1:0]   rd_data;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready, rd_data_valid, rd_data
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready, rd_data_valid, rd_data
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Purpose : Fetches inst_num instruction words from DDR with length-limited,
//           credit-checked read bursts, buffers them in a 2**FIFO_AW FIFO and
//           presents the head word to the controller, popping on inst_req.
// Ports   : clk, rst_n (synchronous, active low)
//           start, inst_ddr_st_addr, inst_num   job launch
//           busy, done, ovf_err, udf_err        status (errors sticky)
//           ddr                                 DDR read channel (master)
//           instruct, inst_empty, inst_req      instruction head / pop
module inst_fetch_unit #(
    parameter int unsigned INST_LEN     = 220,
    parameter int unsigned DDR_DATA_W   = 256,
    parameter int unsigned DDR_ADDR_LEN = 32,
    parameter int unsigned SINGLE_LEN   = 24,
    parameter int unsigned INST_BYTES   = 32,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DDR_ADDR_LEN-1:0] inst_ddr_st_addr,
    input  logic [SINGLE_LEN-1:0]   inst_num,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf_err,
    output logic                    udf_err,
    inst_fetch_unit_if.master       ddr,
    output logic [INST_LEN-1:0]     instruct,
    output logic                    inst_empty,
    input  logic                    inst_req
);
    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned CNT_W  = FIFO_AW + 1;
    localparam int unsigned FREE_W = FIFO_AW + 2;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
    logic [SINGLE_LEN-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic                    req_valid_q, req_valid_d;
    logic [DDR_ADDR_LEN-1:0] req_addr_q, req_addr_d;
    logic [LEN_W-1:0]        req_len_q, req_len_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [INST_LEN-1:0]     mem_q [DEPTH];

    logic                    pop_c, wr_en_c, hs_c, beat_ret_c;
    logic [FREE_W-1:0]       free_c;
    logic [LEN_W-1:0]        burst_len_c;

    // A full FIFO still takes a beat when a pop frees a slot the same cycle.
    assign pop_c      = inst_req && (count_q != '0);
    assign wr_en_c    = ddr.rd_data_valid && ((count_q != CNT_W'(DEPTH)) || pop_c);
    assign hs_c       = req_valid_q && ddr.rd_req_ready;
    // Saturate so stray beats with no credit outstanding cannot wrap the counter.
    assign beat_ret_c = ddr.rd_data_valid && (outstanding_q != '0);

    // Free space counts slots already promised to in-flight beats.
    assign free_c = FREE_W'(DEPTH) - FREE_W'(count_q) - FREE_W'(outstanding_q);
    assign burst_len_c = (remaining_q >= SINGLE_LEN'(MAX_BURST)) ? LEN_W'(MAX_BURST)
                                                                  : LEN_W'(remaining_q);

    // Next-state: FIFO bookkeeping, credit tracking, request issue and FSM.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_len_d     = req_len_q;
        done_d        = 1'b0;
        ovf_d         = ovf_q;
        udf_d         = udf_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        outstanding_d = outstanding_q + (hs_c ? CNT_W'(req_len_q) : CNT_W'(0))
                        - CNT_W'(beat_ret_c);

        if (pop_c)   rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        if (wr_en_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (inst_req && (count_q == '0)) udf_d = 1'b1;
        if (ddr.rd_data_valid && !wr_en_c) ovf_d = 1'b1;

        // Accepted burst: advance and force a bubble before the next request.
        if (hs_c) begin
            req_valid_d = 1'b0;
            addr_d      = addr_q + DDR_ADDR_LEN'(req_len_q) * DDR_ADDR_LEN'(INST_BYTES);
            remaining_d = remaining_q - SINGLE_LEN'(req_len_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = inst_ddr_st_addr;
                    remaining_d = inst_num;
                    state_d     = (inst_num == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (remaining_q == '0) begin
                    state_d = S_WAIT;
                end else if (!req_valid_q && (free_c >= FREE_W'(burst_len_c))) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = addr_q;
                    req_len_d   = burst_len_c;
                end
            end
            S_WAIT: begin
                if (outstanding_q == '0) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and FIFO storage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_len_q     <= '0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mem_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_len_q     <= req_len_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (wr_en_c) mem_q[wr_ptr_q] <= ddr.rd_data[INST_LEN-1:0];
        end
    end

    // Only the low INST_LEN bits of a beat carry the instruction.
    if (DDR_DATA_W > INST_LEN) begin : g_data_hi
        logic unused_data_hi;
        assign unused_data_hi = ^ddr.rd_data[DDR_DATA_W-1:INST_LEN];
    end

    assign ddr.rd_req_valid = req_valid_q;
    assign ddr.rd_req_addr  = req_addr_q;
    assign ddr.rd_req_len   = req_len_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign ovf_err          = ovf_q;
    assign udf_err          = udf_q;
    assign instruct         = mem_q[rd_ptr_q];
    assign inst_empty       = (count_q == '0);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Purpose : Directed and randomized bench for inst_fetch_unit. A DDR model
//           answers accepted bursts with random words after a latency; a
//           queue-based FIFO model predicts head word, empty flag, errors,
//           request addresses/lengths, credit use and job completion.
module tb_inst_fetch_unit;
    localparam int unsigned INST_LEN     = 220;
    localparam int unsigned DDR_DATA_W   = 256;
    localparam int unsigned DDR_ADDR_LEN = 32;
    localparam int unsigned SINGLE_LEN   = 24;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned MAX_BURST    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n, start, inst_req;
    logic [DDR_ADDR_LEN-1:0] st_addr;
    logic [SINGLE_LEN-1:0]   num;
    logic                    busy, done, ovf_err, udf_err, inst_empty;
    logic [INST_LEN-1:0]     instruct;

    inst_fetch_unit_if #(.DDR_ADDR_LEN(DDR_ADDR_LEN), .DDR_DATA_W(DDR_DATA_W)) ddr_if ();

    inst_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .inst_ddr_st_addr (st_addr),
        .inst_num         (num),
        .busy             (busy),
        .done             (done),
        .ovf_err          (ovf_err),
        .udf_err          (udf_err),
        .ddr              (ddr_if.master),
        .instruct         (instruct),
        .inst_empty       (inst_empty),
        .inst_req         (inst_req)
    );

    typedef struct {
        logic [INST_LEN-1:0] w;
        int                  due;
    } beat_t;

    logic [INST_LEN-1:0] fifo_m [$];
    beat_t               pend [$];
    int                  cyc, n_assert, n_fail;
    bit                  op_active, exp_busy, ovf_m, udf_m, done_seen, drv_stray;
    logic [31:0]         exp_addr;
    int                  exp_rem, num_m, delivered, outstanding_m, hs_cnt;
    int                  ready_pct, pop_mode, pop_pct, lat;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INST_LEN-1:0] rand_word();
        logic [INST_LEN-1:0] r = '0;
        for (int i = 0; i < 7; i++) r = (r << 32) | INST_LEN'($urandom);
        return r;
    endfunction

    task automatic drive_beat(input logic [INST_LEN-1:0] w, input bit stray);
        logic [DDR_DATA_W-INST_LEN-1:0] junk;
        junk = {$urandom, 4'($urandom)};
        ddr_if.rd_data_valid = 1'b1;
        ddr_if.rd_data       = {junk, w};
        drv_stray            = stray;
    endtask

    // One clock: record inputs, advance, update model, compare, set next inputs.
    task automatic tick();
        bit                  p_hs, p_valid, p_ready, p_beat, p_pop, p_start, p_rst, p_stray;
        logic [31:0]         p_addr, p_st_addr;
        logic [7:0]          p_len;
        logic [23:0]         p_num;
        logic [INST_LEN-1:0] p_w;
        beat_t               b;
        p_valid   = ddr_if.rd_req_valid;
        p_ready   = ddr_if.rd_req_ready;
        p_hs      = p_valid && p_ready;
        p_addr    = ddr_if.rd_req_addr;
        p_len     = ddr_if.rd_req_len;
        p_beat    = ddr_if.rd_data_valid;
        p_w       = ddr_if.rd_data[INST_LEN-1:0];
        p_stray   = drv_stray;
        p_pop     = inst_req;
        p_start   = start;
        p_st_addr = st_addr;
        p_num     = num;
        p_rst     = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!p_rst) begin
            fifo_m.delete();
            pend.delete();
            outstanding_m = 0;
            ovf_m = 0; udf_m = 0;
            op_active = 0; exp_busy = 0; exp_rem = 0;
        end else begin
            if (p_hs) begin
                check("req_expected", 256'(op_active && exp_rem > 0), 256'(1));
                check("req_addr", 256'(p_addr), 256'(exp_addr));
                check("req_len", 256'(p_len), 256'((exp_rem > int'(MAX_BURST)) ? int'(MAX_BURST) : exp_rem));
                check("req_credit", 256'(fifo_m.size() + outstanding_m + int'(p_len) <= int'(DEPTH)), 256'(1));
                hs_cnt++;
                for (int i = 0; i < int'(p_len); i++) pend.push_back('{w: rand_word(), due: cyc + lat - 1});
                exp_addr      = exp_addr + 32'(p_len) * 32;
                exp_rem       = exp_rem - int'(p_len);
                outstanding_m = outstanding_m + int'(p_len);
            end
            if (p_pop) begin
                if (fifo_m.size() == 0) udf_m = 1;
                else void'(fifo_m.pop_front());
            end
            if (p_beat) begin
                if (!p_stray) begin outstanding_m--; delivered++; end
                if (fifo_m.size() < int'(DEPTH)) fifo_m.push_back(p_w);
                else ovf_m = 1;
            end
            if (p_start && !op_active) begin
                op_active = 1; exp_busy = 1;
                exp_addr = p_st_addr; exp_rem = int'(p_num); num_m = int'(p_num);
                delivered = 0; hs_cnt = 0;
            end
            if (p_valid && !p_ready) begin
                check("req_hold_valid", 256'(ddr_if.rd_req_valid), 256'(1));
                check("req_hold_addr", 256'(ddr_if.rd_req_addr), 256'(p_addr));
                check("req_hold_len", 256'(ddr_if.rd_req_len), 256'(p_len));
            end
            if (p_hs) check("req_gap", 256'(ddr_if.rd_req_valid), 256'(0));
            if (done === 1'b1) begin
                check("done_ok", 256'(op_active && delivered == num_m && fifo_m.size() == 0
                                      && pend.size() == 0 && outstanding_m == 0), 256'(1));
                op_active = 0; exp_busy = 0; done_seen = 1;
            end
            check("busy", 256'(busy), 256'(exp_busy));
            check("inst_empty", 256'(inst_empty), 256'(fifo_m.size() == 0));
            if (fifo_m.size() > 0) check("head_word", 256'(instruct), 256'(fifo_m[0]));
            check("ovf_err", 256'(ovf_err), 256'(ovf_m));
            check("udf_err", 256'(udf_err), 256'(udf_m));
        end
        start = 1'b0;
        ddr_if.rd_data_valid = 1'b0;
        drv_stray = 0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            b = pend.pop_front();
            drive_beat(b.w, 0);
        end
        inst_req = (fifo_m.size() > 0) &&
                   ((pop_mode == 1) || (pop_mode == 2 && int'($urandom_range(99)) < pop_pct));
        ddr_if.rd_req_ready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic start_op(input logic [31:0] a, input int n);
        st_addr = a;
        num     = SINGLE_LEN'(n);
        start   = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget);
        done_seen = 0;
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check("done_timeout", 256'(done_seen), 256'(1));
    endtask

    task automatic wait_filled(input int words, input int budget);
        for (int i = 0; i < budget && !(fifo_m.size() == words && pend.size() == 0); i++) tick();
        check("fill_inst_empty", 256'(inst_empty), 256'(0));
        check("fill_level_reached", 256'(fifo_m.size() == words), 256'(1));
    endtask

    task automatic reset_check();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_ovf", 256'(ovf_err), 256'(0));
        check("rst_udf", 256'(udf_err), 256'(0));
        check("rst_req_valid", 256'(ddr_if.rd_req_valid), 256'(0));
        check("rst_req_addr", 256'(ddr_if.rd_req_addr), 256'(0));
        check("rst_req_len", 256'(ddr_if.rd_req_len), 256'(0));
        check("rst_inst_empty", 256'(inst_empty), 256'(1));
        check("rst_instruct", 256'(instruct), 256'(0));
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; inst_req = 1'b0; st_addr = '0; num = '0;
        ddr_if.rd_req_ready = 1'b0; ddr_if.rd_data_valid = 1'b0; ddr_if.rd_data = '0;
        drv_stray = 0; ready_pct = 100; pop_mode = 0; pop_pct = 50; lat = 2;
        tick();
        tick();
        reset_check();
        rst_n = 1'b1;
        tick();

        // Three-word job, single burst, data two cycles after the request.
        start_op(32'h1000, 3);
        wait_filled(3, 30);
        check("t1_one_burst", 256'(hs_cnt), 256'(1));
        pop_mode = 1;
        wait_done(30);
        check("t1_busy_low", 256'(busy), 256'(0));

        // Twenty words, no pops: third burst waits for space.
        pop_mode = 0; lat = 1;
        start_op(32'h0, 20);
        wait_filled(16, 100);
        check("t2_two_bursts", 256'(hs_cnt), 256'(2));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_withheld", 256'(ddr_if.rd_req_valid), 256'(0));
        end
        // Full FIFO: write with pop is accepted, write without pop is dropped.
        inst_req = 1'b1;
        drive_beat(rand_word(), 1);
        tick();
        check("t4_no_ovf", 256'(ovf_err), 256'(0));
        drive_beat(rand_word(), 1);
        tick();
        check("t4_ovf", 256'(ovf_err), 256'(1));
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1;
            tick();
            check("t2_withheld_pops", 256'(ddr_if.rd_req_valid), 256'(0));
        end
        tick();
        check("t2_third_valid", 256'(ddr_if.rd_req_valid), 256'(1));
        check("t2_third_addr", 256'(ddr_if.rd_req_addr), 256'(32'h200));
        check("t2_third_len", 256'(ddr_if.rd_req_len), 256'(4));
        pop_mode = 1;
        wait_done(200);
        check("t2_three_bursts", 256'(hs_cnt), 256'(3));

        // Request stalled by ready low: held stable, counted once.
        ready_pct = 0; pop_mode = 0;
        start_op(32'h4000, 5);
        for (int i = 0; i < 5; i++) tick();
        check("t3_valid_held", 256'(ddr_if.rd_req_valid), 256'(1));
        check("t3_addr", 256'(ddr_if.rd_req_addr), 256'(32'h4000));
        check("t3_len", 256'(ddr_if.rd_req_len), 256'(5));
        ready_pct = 100; pop_mode = 1;
        wait_done(100);
        check("t3_one_burst", 256'(hs_cnt), 256'(1));

        // Pop while empty, then a zero-length job.
        pop_mode = 0;
        inst_req = 1'b1;
        tick();
        check("t5_udf", 256'(udf_err), 256'(1));
        check("t5_still_empty", 256'(inst_empty), 256'(1));
        start_op(32'h3000, 0);
        check("t5_done_not_yet", 256'(done), 256'(0));
        tick();
        check("t5_done_pulse", 256'(done), 256'(1));
        check("t5_no_req", 256'(ddr_if.rd_req_valid), 256'(0));
        tick();
        check("t5_done_one_cycle", 256'(done), 256'(0));
        pop_mode = 1;
        start_op(32'h2000, 4);
        wait_done(60);

        // Reset in the middle of a job.
        lat = 3; pop_mode = 2; pop_pct = 50;
        start_op(32'h8000, 30);
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0; inst_req = 1'b0; ddr_if.rd_data_valid = 1'b0;
        tick();
        reset_check();
        rst_n = 1'b1;
        tick();

        // Randomized jobs.
        for (int k = 0; k < 8; k++) begin
            ready_pct = int'($urandom_range(100, 30));
            pop_pct   = int'($urandom_range(100, 20));
            lat       = int'($urandom_range(5, 1));
            pop_mode  = 2;
            start_op($urandom & 32'hFFFF_FFE0, int'($urandom_range(40, 1)));
            wait_done(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
